a2d_intf: RTL and testbench
===========================

// Module: a2d_intf
// PURPOSE
//   SPI master to the 8-channel 12-bit A2D converter. Converts left load cell, right load cell
//   and battery round-robin: one channel per nxt pulse.
//   Sits directly upstream of Digital_core; its lft_ld/rght_ld/batt outputs feed the core's
//   same-named inputs, and the core's nxt output is this block's trigger.
//   One conversion = two 16-bit SPI transactions: command, then readback of the result.
// PARAMETERS
//   SCLK_DIV  32  clk cycles per SCLK period; even, >= 4
//   LFT_CH     0  A2D channel of left load cell (3b)
//   RGHT_CH    4  A2D channel of right load cell (3b)
//   BATT_CH    5  A2D channel of battery divider (3b)
// PORTS
//   clk        in   1   system clock, all logic on posedge
//   rst        in   1   synchronous, active-high reset
//   nxt        in   1   start next conversion; level sampled, acted on only in IDLE
//   MISO       in   1   A2D serial data out
//   SS_n       out  1   A2D chip select, active low
//   SCLK       out  1   SPI clock, idle high
//   MOSI       out  1   SPI command data
//   lft_ld     out  12  latest left load cell result
//   rght_ld    out  12  latest right load cell result
//   batt       out  12  latest battery result
//   cnv_cmplt  out  1   1-cycle pulse, any result register updated
// BEHAVIOUR
//   Reset values: SS_n=1, SCLK=1, MOSI=0, lft_ld/rght_ld/batt=0, cnv_cmplt=0,
//     channel pointer=LFT, FSM=IDLE.
//   rst mid-transaction aborts immediately. No result is written. Next start is LFT.
//   FSM states, in order: IDLE -> CMD -> GAP -> READ -> DONE -> IDLE.
//   IDLE
//     nxt=1 -> CMD. SS_n falls on the next cycle.
//     nxt while not IDLE is ignored and never queued.
//   Transaction timing (CMD and READ, identical framing):
//     SS_n low for 17*SCLK_DIV clks.
//     Front porch: SCLK high SCLK_DIV/2 clks.
//     16 bit periods, MSB first. Each: SCLK low SCLK_DIV/2, then high SCLK_DIV/2.
//     MOSI: updates on the clk SCLK falls; stable through the rising edge.
//     MISO: captured into the 16b shift reg on the clk SCLK rises.
//     Back porch: SCLK high SCLK_DIV/2 clks, then SS_n rises.
//   Command word, both transactions: {2'b00, ch[2:0], 11'h000}.
//     e.g. ch0=16'h0000, ch4=16'h2000, ch5=16'h2800.
//   Data handling:
//     CMD: MISO data discarded.
//     GAP: SS_n high, SCLK high, for SCLK_DIV/2 clks.
//     READ: shift reg[11:0] is the result; bits [15:12] ignored.
//   DONE (1 cycle, SS_n already high)
//     Write result to the register of the current channel; other two unchanged.
//     Pulse cnv_cmplt.
//     Advance pointer LFT->RGHT->BATT->LFT (wraps after BATT).
//     Return to IDLE. nxt is accepted on the following cycle.
//   Latency, nxt sampled (cycle 0) to cnv_cmplt:
//     1 + 34*SCLK_DIV + SCLK_DIV/2 + 1 clks = 1106 at default.
//   Counters: bit count 0..16, saturating at end of transaction; clk divider wraps mod SCLK_DIV.
//   SCLK never toggles while SS_n=1.
// TESTING
//   rst held 3 clks mid-CMD -> SS_n=1, SCLK=1, MOSI=0, all results 0 next cycle;
//     next conversion uses ch LFT_CH.
//   nxt pulse, A2D model returns 16'h0ABC in READ -> MOSI=16'h0000 both txns;
//     lft_ld=12'hABC; cnv_cmplt at 1106 clks.
//   Three nxt pulses, model returns 0x123, 0x456, 0x789 ->
//     MOSI cmds 0x0000/0x2000/0x2800; lft=0x123, rght=0x456, batt=0x789.
//   Fourth nxt -> pointer wraps: cmd 0x0000 again; only lft_ld changes.
//   nxt held high for whole conversion -> exactly one conversion per IDLE visit;
//     no extra SS_n edge mid-transaction.
//   Model returns 16'hFABC -> result 12'hABC (upper nibble ignored).
//   Check SCLK: 16 falling edges per SS_n-low window; idle high.

Source files
------------

// File: rtl/a2d_intf.sv
// SPI master for the 8-ch 12-bit A2D: round-robin lft/rght/batt, one channel per nxt in IDLE.
// Latency nxt->cnv_cmplt is 1 + 34*SCLK_DIV + SCLK_DIV/2 + 1 clks; nxt outside IDLE is dropped.
module a2d_intf #(
  parameter int         SCLK_DIV = 32,
  parameter logic [2:0] LFT_CH   = 3'd0,
  parameter logic [2:0] RGHT_CH  = 3'd4,
  parameter logic [2:0] BATT_CH  = 3'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt
);

  localparam int            HALF     = SCLK_DIV / 2;
  localparam int            DW       = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(HALF);
  localparam logic [DW-1:0] GAP_LAST = DW'(HALF - 1);
  localparam logic [4:0]    BIT_END  = 5'd16;

  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [4:0]    bit_cnt, bit_nx;
  logic          txn_nx, sclk_nx, fall_nx, capture;
  logic [1:0]    ptr;
  logic [2:0]    ch;
  logic [15:0]   cmd_word;
  logic [11:0]   shreg;

  always_comb begin
    case (ptr)
      2'd1:    ch = RGHT_CH;
      2'd2:    ch = BATT_CH;
      default: ch = LFT_CH;
    endcase
  end

  assign cmd_word = {2'b00, ch, 11'h000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
    end
  end

  // Within a transaction div_cnt wraps mod SCLK_DIV and bit_cnt counts whole SCLK
  // periods; bit 16 is the back porch, so the window is exactly 17*SCLK_DIV clks.
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    case (state)
      IDLE: begin
        div_nx = '0;
        bit_nx = '0;
        if (nxt) state_nx = CMD;
      end
      CMD, READ: begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          if (bit_cnt == BIT_END) begin
            bit_nx   = '0;
            state_nx = (state == CMD) ? GAP : DONE;
          end else begin
            bit_nx = bit_cnt + 5'd1;
          end
        end else begin
          div_nx = div_cnt + DW'(1);
        end
      end
      GAP: begin
        if (div_cnt == GAP_LAST) begin
          div_nx   = '0;
          state_nx = READ;
        end else begin
          div_nx = div_cnt + DW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    txn_nx  = (state_nx == CMD) || (state_nx == READ);
    sclk_nx = !(txn_nx && (div_nx >= DIV_HALF) && (bit_nx != BIT_END));
    fall_nx = txn_nx && (div_nx == DIV_HALF) && (bit_nx != BIT_END);
  end

  // First clk with SCLK high after a falling edge.
  assign capture = ((state == CMD) || (state == READ)) && (div_cnt == '0) && (bit_cnt != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      MOSI      <= 1'b0;
      shreg     <= '0;
      ptr       <= 2'd0;
      lft_ld    <= '0;
      rght_ld   <= '0;
      batt      <= '0;
      cnv_cmplt <= 1'b0;
    end else begin
      SS_n      <= !txn_nx;
      SCLK      <= sclk_nx;
      cnv_cmplt <= (state == DONE);
      if (!txn_nx)
        MOSI <= 1'b0;
      else if (fall_nx)
        MOSI <= cmd_word[4'd15 - bit_nx[3:0]];
      // Only the low 12 bits are kept; the upper nibble shifts straight out.
      if (capture)
        shreg <= {shreg[10:0], MISO};
      if (state == DONE) begin
        case (ptr)
          2'd1:    rght_ld <= shreg;
          2'd2:    batt    <= shreg;
          default: lft_ld  <= shreg;
        endcase
        ptr <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: A2D slave model on MISO, SPI frame monitor, and a channel/result reference model.
module tb_a2d_intf;

  localparam int DIV = 32;
  localparam int LAT = 1 + 34*DIV + DIV/2 + 1;
  localparam int WIN = 17*DIV;

  logic        clk = 1'b0;
  logic        rst, nxt, MISO;
  logic        SS_n, SCLK, MOSI, cnv_cmplt;
  logic [11:0] lft_ld, rght_ld, batt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  a2d_intf #(.SCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .nxt(nxt), .MISO(MISO),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
    .cnv_cmplt(cnv_cmplt)
  );

  // Reference model: channel order and result registers
  logic [2:0]  ch_of [3] = '{3'd0, 3'd4, 3'd5};
  logic [11:0] exp_res [3];
  int          ptr_m;
  logic [15:0] read_word;

  // Frame monitor + A2D slave, sampled on the falling clk edge
  logic [15:0] win_cmd [$];
  int          win_len [$];
  int          win_falls [$];
  int          idle_viol = 0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b1, par = 1'b0;
  logic [15:0] cur_word, mosi_sr;
  int          len, falls;

  always @(negedge clk) begin
    if (rst) begin
      par       = 1'b0;
      prev_ss   = 1'b1;
      prev_sclk = 1'b1;
      MISO      = 1'b0;
    end else begin
      if (SS_n && !SCLK) idle_viol++;
      if (prev_ss && !SS_n) begin
        cur_word = par ? read_word : 16'($urandom);
        len = 0; falls = 0; mosi_sr = '0;
        MISO = cur_word[15];
      end
      if (!SS_n) begin
        len++;
        if (prev_sclk && !SCLK) begin
          if (falls < 16) MISO = cur_word[15 - falls];
          falls++;
        end
        if (!prev_sclk && SCLK) mosi_sr = {mosi_sr[14:0], MOSI};
      end
      if (!prev_ss && SS_n) begin
        win_cmd.push_back(mosi_sr);
        win_len.push_back(len);
        win_falls.push_back(falls);
        par = ~par;
      end
      prev_ss   = SS_n;
      prev_sclk = SCLK;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, " lft_ld"},  32'(lft_ld),  32'(exp_res[0]));
    chk({tag, " rght_ld"}, 32'(rght_ld), 32'(exp_res[1]));
    chk({tag, " batt"},    32'(batt),    32'(exp_res[2]));
  endtask

  task automatic chk_windows(input string tag, input int rd, input int cnt, input int p0);
    chk({tag, " window count"}, 32'(win_cmd.size() - rd), 32'(cnt));
    if (win_cmd.size() - rd == cnt) begin
      for (int i = 0; i < cnt; i++) begin
        chk({tag, " mosi cmd"}, 32'(win_cmd[rd+i]),
            32'({2'b00, ch_of[(p0 + i/2) % 3], 11'h000}));
        chk({tag, " ss_n low clks"}, 32'(win_len[rd+i]), 32'(WIN));
        chk({tag, " sclk falls"},    32'(win_falls[rd+i]), 32'd16);
      end
    end
  endtask

  // Wait for cnv_cmplt; n counts clk edges after the sampling edge
  task automatic wait_cmplt(output int n);
    n = 0;
    while (n < 3*LAT) begin
      @(posedge clk); #1;
      n++;
      if (cnv_cmplt) break;
    end
  endtask

  task automatic do_conv(input logic [15:0] rw, input string tag);
    int rd, n, p;
    read_word = rw;
    rd = win_cmd.size();
    p  = ptr_m;
    @(negedge clk) nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    wait_cmplt(n);
    // A downstream block samples the pulse on the edge after it appears
    chk({tag, " latency"}, 32'(n + 1), 32'(LAT));
    exp_res[p] = rw[11:0];
    ptr_m = (p + 1) % 3;
    chk_results(tag);
    chk_windows(tag, rd, 2, p);
    @(posedge clk); #1;
    chk({tag, " cnv_cmplt width"}, 32'(cnv_cmplt), 32'd0);
  endtask

  initial begin
    int rd, n1, n2, p;
    rst = 1'b1; nxt = 1'b0;
    for (int i = 0; i < 3; i++) exp_res[i] = '0;
    ptr_m = 0;
    read_word = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset SS_n", 32'(SS_n), 32'd1);
    chk("reset SCLK", 32'(SCLK), 32'd1);
    chk("reset MOSI", 32'(MOSI), 32'd0);
    chk("reset cnv_cmplt", 32'(cnv_cmplt), 32'd0);
    chk_results("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    do_conv(16'h0ABC, "abc");
    do_conv(16'h0456, "rght");
    do_conv(16'h0789, "batt");
    do_conv(16'h0123, "wrap");
    do_conv(16'hFABC, "nibble");
    for (int i = 0; i < 6; i++) do_conv(16'($urandom), "rand");

    // nxt held high across two conversions
    rd = win_cmd.size();
    p  = ptr_m;
    read_word = 16'($urandom);
    @(negedge clk) nxt = 1'b1;
    @(posedge clk); #1;
    wait_cmplt(n1);
    chk("held first latency", 32'(n1 + 1), 32'(LAT));
    exp_res[ptr_m] = read_word[11:0];
    ptr_m = (ptr_m + 1) % 3;
    chk_results("held first");
    read_word = 16'($urandom);
    wait_cmplt(n2);
    nxt = 1'b0;
    chk("held cmplt spacing", 32'(n2), 32'(LAT));
    exp_res[ptr_m] = read_word[11:0];
    ptr_m = (ptr_m + 1) % 3;
    chk_results("held second");
    repeat (50) @(posedge clk);
    #1;
    chk("held stays idle", 32'(SS_n), 32'd1);
    chk_windows("held", rd, 4, p);

    // reset in the middle of a command transaction
    read_word = 16'h0DEF;
    @(negedge clk) nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst SS_n", 32'(SS_n), 32'd1);
    chk("midrst SCLK", 32'(SCLK), 32'd1);
    chk("midrst MOSI", 32'(MOSI), 32'd0);
    for (int i = 0; i < 3; i++) exp_res[i] = '0;
    ptr_m = 0;
    chk_results("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    do_conv(16'($urandom), "after rst");

    chk("sclk idle high", 32'(idle_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
